// File: rtl/output_deskew_pkg.sv
// output_deskew_pkg: default geometry shared by the deskew top and its column FIFOs
package output_deskew_pkg;
  localparam int OUT_DATA_WIDTH = 32;
  localparam int COL = 8;
  localparam int DEPTH = 8;
  localparam int PTR_SIZE = $clog2(DEPTH);
  localparam int CNT_WIDTH = 16;
endpackage

// File: rtl/output_deskew_fifo.sv
// deskew_fifo: first-word-fall-through column FIFO with occupancy count
module deskew_fifo
  import output_deskew_pkg::*;
#(
  parameter int W = OUT_DATA_WIDTH,
  parameter int N = DEPTH,
  parameter int PW = PTR_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wen,
  input  logic         ren,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [PW:0]  count
);
  logic [W-1:0] mem [N];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (wen) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wen);
      rd_ptr <= rd_ptr + PW'(ren);
      count <= count + (PW+1)'(wen) - (PW+1)'(ren);
    end
  end
  assign dout = mem[rd_ptr];
  assign empty = count == '0;
  assign full = count == (PW+1)'(N);
endmodule

// File: rtl/output_deskew.sv
// output_deskew: realigns the skewed array result wavefront into whole rows behind a valid/ready register
module output_deskew #(
  parameter int OUT_DATA_WIDTH = output_deskew_pkg::OUT_DATA_WIDTH,
  parameter int COL = output_deskew_pkg::COL,
  parameter int DEPTH = output_deskew_pkg::DEPTH,
  parameter int PTR_SIZE = $clog2(DEPTH),
  parameter int CNT_WIDTH = output_deskew_pkg::CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic [COL-1:0]                in_valid,
  input  logic [OUT_DATA_WIDTH*COL-1:0] in_data,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [OUT_DATA_WIDTH*COL-1:0] out_data,
  output logic                          isempty,
  output logic                          isfull,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          row_cnt
);
  logic [COL-1:0] empty, full, wen, drop;
  logic [OUT_DATA_WIDTH*COL-1:0] heads;
  logic [PTR_SIZE:0] cnt [COL];
  logic pop, any_word;
  assign pop = ~|empty && (!out_valid || out_ready);
  genvar i;
  generate
    for (i = 0; i < COL; i++) begin : g_col
      // a full column still takes a word when the same cycle pops its head
      assign wen[i] = en && in_valid[i] && (!full[i] || pop);
      assign drop[i] = en && in_valid[i] && full[i] && !pop;
      deskew_fifo #(.W(OUT_DATA_WIDTH), .N(DEPTH), .PW(PTR_SIZE)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .wen   (wen[i]),
        .ren   (pop),
        .din   (in_data[OUT_DATA_WIDTH*i +: OUT_DATA_WIDTH]),
        .dout  (heads[OUT_DATA_WIDTH*i +: OUT_DATA_WIDTH]),
        .empty (empty[i]),
        .full  (full[i]),
        .count (cnt[i])
      );
    end
  endgenerate
  always_comb begin
    any_word = 1'b0;
    for (int k = 0; k < COL; k++) any_word = any_word | (|cnt[k]);
  end
  assign isempty = !any_word && !out_valid;
  assign isfull = |full;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data <= heads;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      row_cnt <= '0;
    end else begin
      overflow <= overflow | (|drop);
      row_cnt <= row_cnt + CNT_WIDTH'(out_valid && out_ready && !flush);
    end
  end
endmodule
